// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM state encoding and field packing for fp producers.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package fp_pkg;
    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_W      = 32;
    localparam int MANT_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    // mant is normalised with its hidden one at the MSB; the bits below the fraction are dropped.
    function automatic logic [FP_W-1:0] fp_pack(
        input logic                sign,
        input logic [FP_EXP_W-1:0] exp,
        input logic [MANT_W-1:0]   mant
    );
        return {sign, exp, mant[MANT_W-2 -: FP_FRAC_W]};
    endfunction
endpackage

// File: rtl/fp_field_pack.sv
// Assembles {sign, exp, fraction} from a normalised mantissa and flags truncated nonzero bits.
// Latency: combinational.
// Backpressure: none; the caller registers the result when it is wanted.
module fp_field_pack
    import fp_pkg::*;
(
    input  logic                sign,
    input  logic [FP_EXP_W-1:0] exp,
    input  logic [MANT_W-1:0]   mant,
    output logic [FP_W-1:0]     fp,
    output logic                inexact
);
    assign fp      = fp_pack(sign, exp, mant);
    assign inexact = |mant[MANT_W-FP_FRAC_W-2:0];
endmodule

// File: rtl/int_to_fp_seq.sv
// Integer to single-precision float converter, normalising one bit per cycle with truncation.
// Latency: leading-zero count + 1 cycles after accept; zero input is presented on the accept edge.
// Backpressure: result held in DONE until out_ready; no new input is accepted until then.
module int_to_fp_seq
    import fp_pkg::*;
#(
    parameter int INT_W   = 32,
    parameter int FP_BIAS = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_int,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_fp,
    output logic             out_inexact
);
    state_t              state;
    logic                sign_q;
    logic [FP_EXP_W-1:0] exp_q;
    logic [MANT_W-1:0]   mant_q;

    logic                neg;
    logic [INT_W-1:0]    mag;
    logic [FP_W-1:0]     packed_fp;
    logic                packed_inexact;

    // Negating in 32 bits maps -2^31 onto 0x80000000, which is its correct magnitude.
    assign neg = in_signed & in_int[INT_W-1];
    assign mag = neg ? (~in_int + 32'd1) : in_int;

    // Ready is gated by reset directly so it falls with rst and rises as soon as rst releases.
    assign in_ready = (state == IDLE) & ~rst;

    fp_field_pack u_pack (
        .sign    (sign_q),
        .exp     (exp_q),
        .mant    (mant_q),
        .fp      (packed_fp),
        .inexact (packed_inexact)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            out_valid   <= 1'b0;
            out_fp      <= '0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (mag == '0) begin
                            // Zero is always +0 and skips normalisation entirely.
                            sign_q      <= 1'b0;
                            out_fp      <= '0;
                            out_inexact <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            sign_q <= neg;
                            mant_q <= mag;
                            exp_q  <= FP_EXP_W'(FP_BIAS + INT_W - 1);
                            state  <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mant_q[MANT_W-1]) begin
                        out_fp      <= packed_fp;
                        out_inexact <= packed_inexact;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_to_fp_seq.sv
// Directed-vector bench with a scoreboard queue; a monitor checks each presented result and its latency.
module tb_int_to_fp_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic        out_inexact;

    int_to_fp_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_int      (in_int),
        .in_signed   (in_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_fp      (out_fp),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fp;
        logic        inex;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic seen   = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: checks the first cycle of each presented result against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst || !out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected no output", out_fp);
            end else begin
                e = sb.pop_front();
                chk("out_fp", out_fp, e.fp);
                chk("out_inexact", 32'(out_inexact), 32'(e.inex));
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
        if (out_valid && out_ready) seen = 1'b0;
    end

    task automatic send(input logic [31:0] val, input logic sgn,
                        input logic [31:0] efp, input logic einex, input int elat);
        exp_t e;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_int    = val;
        in_signed = sgn;
        e.fp   = efp;
        e.inex = einex;
        e.lat  = elat;
        e.acc  = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_int   = $urandom;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: got pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (out_valid) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout: got out_valid=0 expected 1");
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_int    = '0;
        in_signed = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_fp", out_fp, 32'h0);
        chk("rst_out_inexact", 32'(out_inexact), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        send(32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0, 32); wait_idle();
        send(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 32); wait_idle();
        send(32'hFFFF_FFFF, 1'b0, 32'h4F7F_FFFF, 1'b1, 1);  wait_idle();
        send(32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 1);  wait_idle();
        send(32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0, 1);  wait_idle();
        send(32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 0);  wait_idle();
        send(32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 0);  wait_idle();
        send(32'h7FFF_FFFF, 1'b1, 32'h4EFF_FFFF, 1'b1, 2);  wait_idle();
        send(32'h0000_1234, 1'b0, 32'h4591_A000, 1'b0, 20); wait_idle();
        send(32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0, 30); wait_idle();
        send(32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 8);  wait_idle();

        // Stall the consumer while the producer keeps offering new operands.
        out_ready = 1'b0;
        send(32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_int   = $urandom;
            @(negedge clk);
            chk("hold_out_fp", out_fp, 32'hCF00_0000);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (40) @(negedge clk);
        chk("no_second_accept", 32'(out_valid), 32'd0);

        // Abort a long conversion with reset mid-normalisation.
        send(32'h0000_0001, 1'b1, 32'h3F80_0000, 1'b0, 32);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready_release", 32'(in_ready), 32'd1);
        send(32'h7FFF_FFFF, 1'b1, 32'h4EFF_FFFF, 1'b1, 2); wait_idle();
        send(32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0, 30); wait_idle();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
